// File: rtl/time_display_if.sv
// time_display_if: time word in, multiplexed seven-segment drive out
interface time_display_if;
   logic [23:0] t_in;
   logic [5:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;
   modport master (output t_in, input an, seg, dp, frame_done);
   modport slave (input t_in, output an, seg, dp, frame_done);
endinterface

// File: rtl/time_display.sv
// time_display: six-digit multiplexed common-anode driver with per-frame time snapshot
module time_display #(
   parameter int SCAN_DIV = 50000,
   parameter bit BLANK_LZ = 1'b1
) (
   input logic clk,
   input logic clr,
   time_display_if.slave bus
);
   localparam int PW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] P_MAX = PW'(SCAN_DIV - 1);
   logic [PW-1:0] p_q, p_d;
   logic [2:0]    d_q, d_d;
   logic [23:0]   sh_q, sh_d, shr;
   logic          lp_q, lp_d;
   logic [5:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d, fd_q, fd_d, tick, wrap;
   logic [3:0]    v;
   function automatic logic [6:0] enc(input logic [3:0] x);
      case (x)
         4'd0: enc = 7'b1000000;
         4'd1: enc = 7'b1111001;
         4'd2: enc = 7'b0100100;
         4'd3: enc = 7'b0110000;
         4'd4: enc = 7'b0011001;
         4'd5: enc = 7'b0010010;
         4'd6: enc = 7'b0000010;
         4'd7: enc = 7'b1111000;
         4'd8: enc = 7'b0000000;
         4'd9: enc = 7'b0010000;
         default: enc = 7'b0111111;
      endcase
   endfunction
   always_comb begin
      tick = p_q == P_MAX;
      wrap = tick && d_q == 3'd5;
      p_d = tick ? '0 : p_q + 1'b1;
      d_d = tick ? (wrap ? 3'd0 : d_q + 3'd1) : d_q;
      sh_d = (lp_q || wrap) ? bus.t_in : sh_q;
      lp_d = 1'b0;
      shr = sh_q >> {d_q, 2'b00};
      v = shr[3:0];
      an_d = p_q == '0 ? 6'h3f : ~(6'b1 << d_q);
      seg_d = (BLANK_LZ && d_q == 3'd5 && v == 4'd0) ? 7'h7f : enc(v);
      dp_d = !((d_q == 3'd2 || d_q == 3'd4) && !sh_q[0]);
      fd_d = wrap;
   end
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         p_q <= '0;
         d_q <= 3'd0;
         sh_q <= '0;
         lp_q <= 1'b1;
         an_q <= 6'h3f;
         seg_q <= 7'h7f;
         dp_q <= 1'b1;
         fd_q <= 1'b0;
      end else begin
         p_q <= p_d;
         d_q <= d_d;
         sh_q <= sh_d;
         lp_q <= lp_d;
         an_q <= an_d;
         seg_q <= seg_d;
         dp_q <= dp_d;
         fd_q <= fd_d;
      end
   end
   assign bus.an = an_q;
   assign bus.seg = seg_q;
   assign bus.dp = dp_q;
   assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_time_display.sv
// tb_time_display: randomized and directed scan checks of two instances against a frame-arithmetic model
module tb_time_display;
   localparam int S = 4;
   localparam logic [69:0] DIG = {7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
                                  7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000};
   logic clk = 1'b0;
   logic clr;
   logic [23:0] t_in;
   int checks = 0;
   int errors = 0;
   int k;
   logic [23:0] msh;
   time_display_if b1 ();
   time_display_if b0 ();
   assign b1.t_in = t_in;
   assign b0.t_in = t_in;
   time_display #(.SCAN_DIV(S), .BLANK_LZ(1'b1)) u1 (.clk(clk), .clr(clr), .bus(b1.slave));
   time_display #(.SCAN_DIV(S), .BLANK_LZ(1'b0)) u0 (.clk(clk), .clr(clr), .bus(b0.slave));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s k=%0d got=%b exp=%b", tag, k, got, exp);
      end
   endtask
   function automatic logic [6:0] mseg(input logic [3:0] v, input bit blz, input int dg);
      if (blz && dg == 5 && v == 4'd0) return 7'h7f;
      if (v > 4'd9) return 7'b0111111;
      return DIG[v*7 +: 7];
   endfunction
   task automatic chk_reset();
      chk("rst_an1", b1.an, 7'h3f);
      chk("rst_seg1", b1.seg, 7'h7f);
      chk("rst_dp1", b1.dp, 7'd1);
      chk("rst_fd1", b1.frame_done, 7'd0);
      chk("rst_an0", b0.an, 7'h3f);
      chk("rst_seg0", b0.seg, 7'h7f);
   endtask
   // outputs after edge k reflect the scan position held just before that edge
   task automatic step();
      int ph, dg;
      logic [3:0] v;
      logic [5:0] e_an;
      logic e_dp, e_fd;
      @(posedge clk);
      k++;
      ph = (k - 1) % S;
      dg = ((k - 1) / S) % 6;
      v = 4'(msh >> (4 * dg));
      e_an = ph == 0 ? 6'h3f : ~(6'b1 << dg);
      e_dp = !((dg == 2 || dg == 4) && !msh[0]);
      e_fd = ((k - 1) % (6 * S)) == 6 * S - 1;
      if (k == 1 || e_fd) msh = t_in;
      #1;
      chk("an1", b1.an, e_an);
      chk("seg1", b1.seg, mseg(v, 1'b1, dg));
      chk("dp1", b1.dp, e_dp);
      chk("fd1", b1.frame_done, e_fd);
      chk("an0", b0.an, e_an);
      chk("seg0", b0.seg, mseg(v, 1'b0, dg));
      chk("fd0", b0.frame_done, e_fd);
   endtask
   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask
   task automatic run_to(input int pp, input int dd);
      for (int i = 0; i < 6 * S + 1 && !((k % S) == pp && ((k / S) % 6) == dd); i++) step();
   endtask
   initial begin
      clr = 1'b0;
      t_in = 24'h123456;
      k = 0;
      msh = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset();
      clr = 1'b1;
      run(3 * 6 * S);
      t_in = 24'h075959;
      run(2 * 6 * S);
      t_in = 24'h120000;
      run(6 * S + 6);
      t_in = 24'h120001;
      run(2 * 6 * S);
      t_in = 24'h235959;
      run(6 * S);
      run_to(1, 2);
      t_in = 24'h000000;
      run(2 * 6 * S);
      t_in = 24'h00000a;
      run(2 * 6 * S);
      for (int i = 0; i < 240; i++) begin
         if ($urandom_range(3) == 0) t_in = 24'($urandom);
         step();
      end
      t_in = 24'h654321;
      run(6 * S);
      run_to(2, 3);
      #2;
      clr = 1'b0;
      #1;
      chk_reset();
      #1;
      clr = 1'b1;
      k = 0;
      msh = '0;
      run(3 * 6 * S);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
